// File: rtl/spi_slave_gen.sv
// -----------------------------------------------------------------------------
// spi_slave_gen
// Parametrised SPI slave front end for the single-port RAM path.
// A frame starts with a command bit (0 = write, 1 = read) followed by FRAME_W
// bits {opcode[1:0], payload}, MSB first. Complete frames are presented on
// rx_data with a one-cycle rx_valid pulse. A read-data frame then waits up to
// TX_TIMEOUT cycles for tx_valid and shifts tx_data out on MISO, MSB first.
//
// Optional feature macro: SPI_PARITY_EN
//   When defined, each frame carries one extra even-parity bit covering all
//   FRAME_W bits; a mismatch drops the frame and pulses frame_err.
//
// Parameters:
//   DATA_W     payload width (frame width is DATA_W+2)
//   TX_TIMEOUT max cycles to wait for tx_valid in a read-data transaction
//
// Ports:
//   clk             clock, everything happens on posedge
//   rst             asynchronous active-high reset
//   SS_n            slave select, active low
//   MOSI            serial in, MSB first
//   MISO            serial out, MSB first, registered
//   rx_data         received frame {opcode, payload}
//   rx_valid        one-cycle pulse, rx_data valid
//   tx_data         read data from RAM
//   tx_valid        tx_data valid
//   rd_addr_pending read address received, read data not yet returned
//   frame_err       one-cycle pulse on abort, timeout or parity failure
// -----------------------------------------------------------------------------
module spi_slave_gen #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              rd_addr_pending,
  output logic              frame_err
);

  localparam int FRAME_W = DATA_W + 2;
  localparam int CNT_W   = $clog2(FRAME_W + 1);
  localparam int WAIT_W  = $clog2(TX_TIMEOUT + 1);

  localparam logic [CNT_W-1:0]  CNT_FRAME = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0]  CNT_DATA  = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(TX_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4,
    TX_WAIT   = 3'd5,
    TX_SHIFT  = 3'd6,
    DONE      = 3'd7
  } state_t;

  state_t              state_r;
  logic [CNT_W-1:0]    bit_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [FRAME_W-1:0]  rx_sr_r;
  logic [DATA_W-1:0]   tx_sr_r;

  // Shift register contents including the bit currently on MOSI.
  logic [FRAME_W-1:0]  frame_s;
  // Value of bit_cnt_r on the cycle that completes the frame.
  logic [CNT_W-1:0]    cnt_last_s;
  // Frame word published on completion.
  logic [FRAME_W-1:0]  frame_word_s;
  logic                parity_ok_s;

  assign frame_s = {rx_sr_r[FRAME_W-2:0], MOSI};

`ifdef SPI_PARITY_EN
  // Even parity: the parity bit equals the XOR of all covered bits.
  function automatic logic even_parity(input logic [FRAME_W-1:0] d);
    return ^d;
  endfunction

  // The parity bit arrives one cycle after the last payload bit, when the
  // full frame is already sitting in the shift register.
  assign cnt_last_s   = CNT_ZERO;
  assign frame_word_s = rx_sr_r;
  assign parity_ok_s  = (even_parity(rx_sr_r) == MOSI);
`else
  assign cnt_last_s   = CNT_ONE;
  assign frame_word_s = frame_s;
  assign parity_ok_s  = 1'b1;
`endif

  // Frame FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      bit_cnt_r       <= CNT_ZERO;
      wait_cnt_r      <= '0;
      rx_sr_r         <= '0;
      tx_sr_r         <= '0;
      MISO            <= 1'b0;
      rx_data         <= '0;
      rx_valid        <= 1'b0;
      rd_addr_pending <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (state_r)
        IDLE: begin
          MISO <= 1'b0;
          if (!SS_n) begin
            state_r <= CHK_CMD;
          end else begin
            state_r <= IDLE;
          end
        end

        CHK_CMD: begin
          bit_cnt_r <= CNT_FRAME;
          if (SS_n) begin
            state_r   <= IDLE;
            frame_err <= 1'b1;
            MISO      <= 1'b0;
          end else if (!MOSI) begin
            state_r <= WRITE;
          end else if (rd_addr_pending) begin
            state_r <= READ_DATA;
          end else begin
            state_r <= READ_ADD;
          end
        end

        WRITE, READ_ADD, READ_DATA: begin
          if (SS_n) begin
            // Partial frame: rx_data keeps the last complete frame.
            state_r   <= IDLE;
            frame_err <= 1'b1;
            MISO      <= 1'b0;
          end else if (bit_cnt_r != cnt_last_s) begin
            rx_sr_r   <= frame_s;
            bit_cnt_r <= bit_cnt_r - CNT_ONE;
          end else if (parity_ok_s) begin
            rx_data  <= frame_word_s;
            rx_valid <= 1'b1;
            case (state_r)
              WRITE: begin
                state_r <= DONE;
              end
              READ_ADD: begin
                state_r         <= DONE;
                rd_addr_pending <= 1'b1;
              end
              READ_DATA: begin
                state_r    <= TX_WAIT;
                wait_cnt_r <= WAIT_INIT;
              end
              default: begin
                state_r <= IDLE;
              end
            endcase
          end else begin
            state_r   <= DONE;
            frame_err <= 1'b1;
          end
        end

        TX_WAIT: begin
          if (SS_n) begin
            state_r   <= IDLE;
            frame_err <= 1'b1;
            MISO      <= 1'b0;
          end else if (tx_valid) begin
            tx_sr_r   <= tx_data;
            bit_cnt_r <= CNT_DATA;
            state_r   <= TX_SHIFT;
          end else if (wait_cnt_r <= WAIT_ONE) begin
            // Read address stays pending so the master can retry.
            state_r   <= DONE;
            frame_err <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
          end
        end

        TX_SHIFT: begin
          if (SS_n) begin
            state_r   <= IDLE;
            frame_err <= 1'b1;
            MISO      <= 1'b0;
          end else if (bit_cnt_r != CNT_ZERO) begin
            MISO      <= tx_sr_r[DATA_W-1];
            tx_sr_r   <= tx_sr_r << 1;
            bit_cnt_r <= bit_cnt_r - CNT_ONE;
          end else begin
            MISO            <= 1'b0;
            rd_addr_pending <= 1'b0;
            state_r         <= DONE;
          end
        end

        DONE: begin
          MISO <= 1'b0;
          if (SS_n) begin
            state_r <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end

        default: begin
          MISO    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave_gen.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_gen
// Self-checking bench for spi_slave_gen (DATA_W=8, TX_TIMEOUT=15).
// Expected frames are queued when driven and compared when rx_valid fires;
// expected MISO bits are queued when tx_data is offered and compared as they
// are shifted out.
// -----------------------------------------------------------------------------
module tb_spi_slave_gen;

  localparam int DATA_W     = 8;
  localparam int FRAME_W    = DATA_W + 2;
  localparam int TX_TIMEOUT = 15;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               SS_n = 1'b1;
  logic               MOSI = 1'b0;
  logic               MISO;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data = '0;
  logic               tx_valid = 1'b0;
  logic               rd_addr_pending;
  logic               frame_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [FRAME_W-1:0] exp_q[$];
  logic               miso_q[$];

  always #5 clk = ~clk;

  spi_slave_gen #(
    .DATA_W    (DATA_W),
    .TX_TIMEOUT(TX_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .SS_n           (SS_n),
    .MOSI           (MOSI),
    .MISO           (MISO),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .rd_addr_pending(rd_addr_pending),
    .frame_err      (frame_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Select, command bit, FRAME_W frame bits MSB first (plus parity if enabled).
  task automatic send_frame(input logic cmd, input logic [FRAME_W-1:0] frame);
    SS_n = 1'b0;
    tick();
    MOSI = cmd;
    tick();
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      MOSI = frame[i];
      tick();
    end
`ifdef SPI_PARITY_EN
    MOSI = ^frame;
    tick();
`endif
    MOSI = 1'b0;
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    tick();
    tick();
  endtask

  // Scoreboard monitor for received frames.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("rx_err_excl", 32'(rx_valid & frame_err), 32'd0);
      if (rx_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("rx_unexpected", 32'(rx_valid), 32'd0);
        end else begin
          check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int early_err;
    int miso_hi;
    logic [DATA_W-1:0] rd_word;

    // Reset state
    #12;
    check_eq("rst_miso", 32'(MISO), 32'd0);
    check_eq("rst_rx_data", 32'(rx_data), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_pending", 32'(rd_addr_pending), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Write frame
    exp_q.push_back(10'h0A5);
    send_frame(1'b0, 10'h0A5);
    check_eq("wr_rx_valid", 32'(rx_valid), 32'd1);
    check_eq("wr_pending", 32'(rd_addr_pending), 32'd0);
    tick();
    check_eq("wr_rx_valid_1cyc", 32'(rx_valid), 32'd0);
    end_frame();

    // Read address
    exp_q.push_back(10'h233);
    send_frame(1'b1, 10'h233);
    check_eq("ra_pending", 32'(rd_addr_pending), 32'd1);
    end_frame();

    // Read data with tx_valid arriving on the third TX_WAIT cycle
    exp_q.push_back(10'h300);
    send_frame(1'b1, 10'h300);
    check_eq("rd_miso_wait", 32'(MISO), 32'd0);
    tick();
    tick();
    rd_word  = 8'hC3;
    tx_data  = rd_word;
    tx_valid = 1'b1;
    for (int i = DATA_W - 1; i >= 0; i--) miso_q.push_back(rd_word[i]);
    tick();
    tx_valid = 1'b0;
    check_eq("rd_miso_latch", 32'(MISO), 32'd0);
    for (int i = 0; i < DATA_W; i++) begin
      tick();
      check_eq("rd_miso_bit", 32'(MISO), 32'(miso_q.pop_front()));
    end
    tick();
    check_eq("rd_miso_end", 32'(MISO), 32'd0);
    check_eq("rd_pending_clr", 32'(rd_addr_pending), 32'd0);
    end_frame();

    // Timeout: no tx_valid
    exp_q.push_back(10'h2AA);
    send_frame(1'b1, 10'h2AA);
    end_frame();
    exp_q.push_back(10'h3FF);
    send_frame(1'b1, 10'h3FF);
    early_err = 0;
    miso_hi   = 0;
    for (int k = 1; k < TX_TIMEOUT; k++) begin
      tick();
      early_err += int'(frame_err);
      miso_hi   += int'(MISO);
    end
    check_eq("to_early_err", 32'(early_err), 32'd0);
    tick();
    check_eq("to_frame_err", 32'(frame_err), 32'd1);
    check_eq("to_pending", 32'(rd_addr_pending), 32'd1);
    check_eq("to_miso", 32'(miso_hi + int'(MISO)), 32'd0);
    tick();
    check_eq("to_err_1cyc", 32'(frame_err), 32'd0);
    end_frame();

    // Abort after 5 write bits
    SS_n = 1'b0;
    tick();
    MOSI = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      MOSI = 1'b1;
      tick();
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    tick();
    check_eq("ab_frame_err", 32'(frame_err), 32'd1);
    check_eq("ab_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("ab_rx_data", 32'(rx_data), 32'h3FF);
    tick();
    check_eq("ab_err_1cyc", 32'(frame_err), 32'd0);

    // Async reset in the middle of TX_SHIFT (read address still pending)
    exp_q.push_back(10'h3A5);
    send_frame(1'b1, 10'h3A5);
    tx_data  = 8'hB0;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    check_eq("rs_miso_b7", 32'(MISO), 32'd1);
    #2;
    rst  = 1'b1;
    SS_n = 1'b1;
    #1;
    check_eq("rs_miso", 32'(MISO), 32'd0);
    check_eq("rs_rx_valid", 32'(rx_valid), 32'd0);
    check_eq("rs_pending", 32'(rd_addr_pending), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Frames after reset decode as WRITE then READ_ADD
    exp_q.push_back(10'h155);
    send_frame(1'b0, 10'h155);
    check_eq("pr_wr_pending", 32'(rd_addr_pending), 32'd0);
    end_frame();
    exp_q.push_back(10'h2C3);
    send_frame(1'b1, 10'h2C3);
    check_eq("pr_ra_pending", 32'(rd_addr_pending), 32'd1);
    end_frame();

`ifdef SPI_PARITY_EN
    // Good parity is covered by send_frame; here a flipped parity bit
    exp_q.push_back(10'h0A5);
    send_frame(1'b0, 10'h0A5);
    end_frame();
    SS_n = 1'b0;
    tick();
    MOSI = 1'b0;
    tick();
    rd_word = 8'hA5;
    for (int i = FRAME_W - 1; i >= 0; i--) begin
      MOSI = (i < DATA_W) ? rd_word[i] : 1'b0;
      tick();
    end
    MOSI = 1'b1;
    tick();
    MOSI = 1'b0;
    check_eq("par_frame_err", 32'(frame_err), 32'd1);
    check_eq("par_rx_valid", 32'(rx_valid), 32'd0);
    end_frame();
`endif

    tick();
    check_eq("rx_missing", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_gen.md
Name: spi_slave_gen

Overview:
- Parametrised SPI slave front end for the single-port RAM path. Successor to the fixed 10-bit slave.
- Receives command/address/data frames serially on MOSI. Presents each frame in parallel with a one-cycle rx_valid pulse.
- Returns RAM read data on MISO after a tx_valid handshake.
- Adds generic data width, a bounded tx wait, abort/error reporting and a visible read-address status.

Parameters:
DATA_W, 8, payload width; frame width FRAME_W = DATA_W+2 (2-bit opcode + payload)
TX_TIMEOUT, 15, max cycles to wait for tx_valid in a read-data transaction (>=1)

Ports:
clk  input  1  clock; all sampling and driving on posedge
rst  input  1  asynchronous active-high reset
SS_n  input  1  slave select, active low
MOSI  input  1  serial in, MSB first
MISO  output  1  serial out, MSB first, registered
rx_data  output  DATA_W+2  received frame {opcode[1:0], payload}
rx_valid  output  1  one-cycle pulse, rx_data valid
tx_data  input  DATA_W  read data from RAM
tx_valid  input  1  tx_data valid
rd_addr_pending  output  1  read address received, read data not yet returned
frame_err  output  1  one-cycle pulse on abort, timeout (or parity fail)

Behaviour:
- Reset (async, rst=1): state=IDLE; MISO=0, rx_data=0, rx_valid=0, rd_addr_pending=0, frame_err=0; all counters and shift registers cleared. Reset mid-frame abandons the frame with no rx_valid pulse.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA, TX_WAIT, TX_SHIFT, DONE.
- IDLE: SS_n=0 sampled -> CHK_CMD.
- CHK_CMD: sample MOSI:
  - 0 -> WRITE
  - 1 with rd_addr_pending=0 -> READ_ADD
  - 1 with rd_addr_pending=1 -> READ_DATA
  - Bit counter loaded with FRAME_W.
- WRITE / READ_ADD / READ_DATA:
  - Shift one MOSI bit per cycle into rx_data, MSB first, for FRAME_W cycles.
  - In the cycle after the last bit, rx_valid=1 for exactly one cycle.
  - Then: WRITE -> DONE; READ_ADD -> DONE and rd_addr_pending<=1; READ_DATA -> TX_WAIT.
- Opcode bits are passed through unchecked; the RAM decodes them.
- TX_WAIT:
  - First cycle with tx_valid=1: latch tx_data into the tx shift register -> TX_SHIFT.
  - No tx_valid within TX_TIMEOUT cycles: frame_err pulse, rd_addr_pending unchanged -> DONE.
- TX_SHIFT:
  - MISO driven with the shift register MSB, starting the cycle after the latch, one bit per cycle for DATA_W cycles.
  - After the last bit: MISO<=0, rd_addr_pending<=0 -> DONE.
- DONE: hold, MISO=0; SS_n=1 -> IDLE. Extra MOSI bits are ignored.
- Abort: SS_n=1 sampled in CHK_CMD, WRITE, READ_*, TX_WAIT or TX_SHIFT:
  - -> IDLE next cycle, with frame_err pulse; MISO<=0.
  - No rx_valid for a partial frame.
  - rx_data keeps its last complete value; rd_addr_pending unchanged.
- rx_valid and frame_err are never high in the same cycle.
- rx_valid is 0 in all cycles except the single pulse.
- Counter widths sized by $clog2 of FRAME_W+1 and TX_TIMEOUT+1.

Optional Feature:
SPI_PARITY_EN:
- Defined: one extra even-parity bit follows the FRAME_W payload bits in WRITE/READ_ADD/READ_DATA, covering all FRAME_W bits.
- Parity mismatch: no rx_valid, frame_err pulse -> DONE; rd_addr_pending unchanged, and TX_WAIT is not entered.
- On match, rx_valid fires the cycle after the parity bit.
- Undefined: no parity bit, timing exactly as above.

Test Plan (DATA_W=8, TX_TIMEOUT=15):
- Write: SS_n=0, MOSI 0 then 00_10100101 -> after 10 bits rx_data=10'h0A5 with one-cycle rx_valid; rd_addr_pending=0; SS_n=1 -> IDLE.
- Read addr then data: frame 1,10_00110011 -> rx_data=10'h233, rd_addr_pending=1. Then frame 1,11_00000000 -> rx_data=10'h300, rx_valid pulse. Then tx_valid=1 with tx_data=8'hC3 after 3 cycles -> MISO 1,1,0,0,0,0,1,1 on the next 8 cycles, then rd_addr_pending=0.
- Timeout: read-data frame with tx_valid held 0 -> frame_err pulse 15 cycles after TX_WAIT entry; rd_addr_pending stays 1; MISO stays 0.
- Abort: SS_n=1 after 5 WRITE bits -> frame_err pulse, no rx_valid, rx_data unchanged, state IDLE next cycle.
- Async reset: assert rst mid-TX_SHIFT -> MISO, rx_valid and rd_addr_pending go 0 without a clock edge; next frame decodes as WRITE/READ_ADD correctly.
- SPI_PARITY_EN: write 00_10100101 with parity 0 -> rx_valid; same frame with parity 1 -> frame_err, no rx_valid.
